// File: rtl/best_score_register_pkg.sv
// Constants shared by the best-score list, the score pipeline and host readback.
// Also provides the helpers that size the count and index fields.
package best_score_register_pkg;

    localparam int SCORE_W_DEF = 10;
    localparam int TAG_W_DEF   = 64;
    localparam int DEPTH_DEF   = 4;

    localparam logic [SCORE_W_DEF-1:0] SCORE_SENTINEL = '1;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/best_score_register_if.sv
// Candidate handshake from the score pipeline into the best-score list.
// The master offers a candidate; the slave takes it when both valid and ready are high.
interface best_score_register_if
    import best_score_register_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int TAG_W   = TAG_W_DEF
);
    logic               cand_valid;
    logic               cand_ready;
    logic [SCORE_W-1:0] cand_score;
    logic [TAG_W-1:0]   cand_tag;

    modport master (output cand_valid, output cand_score, output cand_tag, input cand_ready);
    modport slave  (input cand_valid, input cand_score, input cand_tag, output cand_ready);
endinterface

// File: rtl/best_score_register_slot.sv
// One list entry, holding a score and its tag. On each clock it either holds its value,
// loads the new candidate, takes the entry from the slot above, or returns to empty.
module best_score_slot
    import best_score_register_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic [SCORE_W-1:0] i_cand_score,
    input  logic [TAG_W-1:0]   i_cand_tag,
    input  logic [SCORE_W-1:0] i_above_score,
    input  logic [TAG_W-1:0]   i_above_tag,
    output logic [SCORE_W-1:0] o_score,
    output logic [TAG_W-1:0]   o_tag
);
    logic [SCORE_W-1:0] r_score;
    logic [TAG_W-1:0]   r_tag;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_score <= '1;
            r_tag   <= '0;
        end else if (i_load) begin
            r_score <= i_cand_score;
            r_tag   <= i_cand_tag;
        end else if (i_shift) begin
            r_score <= i_above_score;
            r_tag   <= i_above_tag;
        end
    end

    assign o_score = r_score;
    assign o_tag   = r_tag;
endmodule

// File: rtl/best_score_register.sv
// Keeps the DEPTH lowest scores, sorted ascending, each with its tag. Candidates are staged
// for one cycle, then placed by a compare against the current list and the limit.
module best_score_register
    import best_score_register_pkg::*;
#(
    parameter  int SCORE_W = SCORE_W_DEF,
    parameter  int TAG_W   = TAG_W_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    localparam int CNT_W   = cnt_width(DEPTH),
    localparam int IDX_W   = idx_width(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_i,
    input  logic [SCORE_W-1:0]        load_score_i,
    input  logic                      clear_i,
    best_score_register_if.slave      cand,
    output logic [SCORE_W-1:0]        limit_o,
    output logic                      best_valid_o,
    output logic [SCORE_W-1:0]        best_score_o,
    output logic [TAG_W-1:0]          best_tag_o,
    output logic                      improved_o,
    output logic [CNT_W-1:0]          count_o,
    input  logic [IDX_W-1:0]          rd_idx_i,
    output logic [SCORE_W-1:0]        rd_score_o,
    output logic [TAG_W-1:0]          rd_tag_o
);
    logic               r_stg_valid;
    logic [SCORE_W-1:0] r_stg_score;
    logic [TAG_W-1:0]   r_stg_tag;
    logic [SCORE_W-1:0] r_thr;
    logic [CNT_W-1:0]   r_count;
    logic               r_improved;

    logic [SCORE_W-1:0] w_score [DEPTH];
    logic [TAG_W-1:0]   w_tag   [DEPTH];
    logic [DEPTH-1:0]   w_le;
    logic [DEPTH-1:0]   w_load;
    logic [DEPTH-1:0]   w_shift;
    logic [SCORE_W-1:0] w_limit;
    logic               w_accept;
    logic               w_ins;
    logic               w_full;

    assign cand.cand_ready = !load_i && !clear_i;
    assign w_accept        = cand.cand_valid && cand.cand_ready;
    assign w_full          = (r_count == CNT_W'(DEPTH));

    always_comb begin
        w_limit = r_thr;
        if (w_full && (w_score[DEPTH-1] < r_thr)) begin
            w_limit = w_score[DEPTH-1];
        end
    end

    assign w_ins = r_stg_valid && (r_stg_score < w_limit) && !clear_i;

    // w_le is a prefix of ones: occupied entries at or below the candidate stay put (older wins ties).
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [SCORE_W-1:0] w_above_score;
            logic [TAG_W-1:0]   w_above_tag;

            assign w_le[gi] = (CNT_W'(gi) < r_count) && (w_score[gi] <= r_stg_score);

            if (gi == 0) begin : g_head
                assign w_load[gi]    = w_ins && !w_le[gi];
                assign w_shift[gi]   = 1'b0;
                assign w_above_score = r_stg_score;
                assign w_above_tag   = r_stg_tag;
            end else begin : g_body
                assign w_load[gi]    = w_ins && w_le[gi-1] && !w_le[gi];
                assign w_shift[gi]   = w_ins && !w_le[gi-1];
                assign w_above_score = w_score[gi-1];
                assign w_above_tag   = w_tag[gi-1];
            end

            best_score_slot #(
                .SCORE_W (SCORE_W),
                .TAG_W   (TAG_W)
            ) u_slot (
                .i_clk         (clk_i),
                .i_rst         (rst_i),
                .i_clear       (clear_i),
                .i_load        (w_load[gi]),
                .i_shift       (w_shift[gi]),
                .i_cand_score  (r_stg_score),
                .i_cand_tag    (r_stg_tag),
                .i_above_score (w_above_score),
                .i_above_tag   (w_above_tag),
                .o_score       (w_score[gi]),
                .o_tag         (w_tag[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stg_valid <= 1'b0;
            r_stg_score <= '1;
            r_stg_tag   <= '0;
            r_thr       <= '1;
            r_count     <= '0;
            r_improved  <= 1'b0;
        end else begin
            if (load_i) begin
                r_thr <= load_score_i;
            end
            if (clear_i) begin
                r_stg_valid <= 1'b0;
                r_count     <= '0;
                r_improved  <= 1'b0;
            end else begin
                r_stg_valid <= w_accept;
                if (w_accept) begin
                    r_stg_score <= cand.cand_score;
                    r_stg_tag   <= cand.cand_tag;
                end
                r_improved <= w_load[0];
                if (w_ins && !w_full) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_score_o = '1;
        rd_tag_o   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                rd_score_o = w_score[i];
                rd_tag_o   = w_tag[i];
            end
        end
    end

    assign limit_o      = w_limit;
    assign best_valid_o = (r_count != '0);
    assign best_score_o = w_score[0];
    assign best_tag_o   = w_tag[0];
    assign improved_o   = r_improved;
    assign count_o      = r_count;
endmodule

// File: tb/tb_best_score_register.sv
// Directed bench for best_score_register (DEPTH=4): insert order, ties, limit, load and clear.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_best_score_register;
    localparam int SCORE_W = 10;
    localparam int TAG_W   = 64;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               load_i;
    logic [SCORE_W-1:0] load_score_i;
    logic               clear_i;
    logic [SCORE_W-1:0] limit_o;
    logic               best_valid_o;
    logic [SCORE_W-1:0] best_score_o;
    logic [TAG_W-1:0]   best_tag_o;
    logic               improved_o;
    logic [2:0]         count_o;
    logic [1:0]         rd_idx_i;
    logic [SCORE_W-1:0] rd_score_o;
    logic [TAG_W-1:0]   rd_tag_o;

    int n_checks = 0;
    int n_fail   = 0;

    best_score_register_if #(.SCORE_W(SCORE_W), .TAG_W(TAG_W)) cif ();

    best_score_register #(.SCORE_W(SCORE_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .load_i       (load_i),
        .load_score_i (load_score_i),
        .clear_i      (clear_i),
        .cand         (cif.slave),
        .limit_o      (limit_o),
        .best_valid_o (best_valid_o),
        .best_score_o (best_score_o),
        .best_tag_o   (best_tag_o),
        .improved_o   (improved_o),
        .count_o      (count_o),
        .rd_idx_i     (rd_idx_i),
        .rd_score_o   (rd_score_o),
        .rd_tag_o     (rd_tag_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [SCORE_W-1:0] s, input logic [TAG_W-1:0] t);
        cif.cand_valid = 1'b1;
        cif.cand_score = s;
        cif.cand_tag   = t;
        $display("push score=%0d tag=%0h ready=%0b", s, t, cif.cand_ready);
        tick();
        cif.cand_valid = 1'b0;
    endtask

    task automatic check_slot(input int idx, input logic [SCORE_W-1:0] s, input logic [TAG_W-1:0] t);
        rd_idx_i = 2'(idx);
        #1;
        check_val($sformatf("slot%0d_score", idx), 64'(rd_score_o), 64'(s));
        check_val($sformatf("slot%0d_tag", idx), rd_tag_o, t);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        $display("clear");
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1;
        load_i = 1'b0;
        load_score_i = '0;
        clear_i = 1'b0;
        rd_idx_i = '0;
        cif.cand_valid = 1'b0;
        cif.cand_score = '0;
        cif.cand_tag   = '0;
        tick();
        tick();
        rst_i = 1'b0;
        $display("reset released");

        // Reset state
        check_val("rst_count", 64'(count_o), 64'd0);
        check_val("rst_limit", 64'(limit_o), 64'h3FF);
        check_val("rst_best_valid", 64'(best_valid_o), 64'd0);
        check_val("rst_improved", 64'(improved_o), 64'd0);
        check_val("rst_ready", 64'(cif.cand_ready), 64'd1);
        for (int i = 0; i < DEPTH; i++) check_slot(i, 10'h3FF, 64'd0);

        // All-ones score is never accepted
        push(10'h3FF, 64'h77);
        tick();
        tick();
        check_val("sentinel_rejected", 64'(count_o), 64'd0);

        // Back-to-back inserts: improved after the 300, 200 and 100 inserts
        push(10'd300, 64'h1);
        check_val("imp_e1", 64'(improved_o), 64'd0);
        push(10'd200, 64'h2);
        check_val("imp_e2", 64'(improved_o), 64'd1);
        push(10'd250, 64'h3);
        check_val("imp_e3", 64'(improved_o), 64'd1);
        push(10'd100, 64'h4);
        check_val("imp_e4", 64'(improved_o), 64'd0);
        tick();
        check_val("imp_e5", 64'(improved_o), 64'd1);
        tick();
        check_val("imp_e6", 64'(improved_o), 64'd0);
        check_slot(0, 10'd100, 64'h4);
        check_slot(1, 10'd200, 64'h2);
        check_slot(2, 10'd250, 64'h3);
        check_slot(3, 10'd300, 64'h1);
        check_val("full_count", 64'(count_o), 64'd4);
        check_val("full_limit", 64'(limit_o), 64'd300);
        check_val("full_best_valid", 64'(best_valid_o), 64'd1);
        check_val("full_best_score", 64'(best_score_o), 64'd100);
        check_val("full_best_tag", best_tag_o, 64'h4);

        // Equal to limit rejected; one below replaces the tail
        push(10'd300, 64'h5);
        push(10'd299, 64'h6);
        tick();
        tick();
        check_slot(2, 10'd250, 64'h3);
        check_slot(3, 10'd299, 64'h6);
        check_val("tail_limit", 64'(limit_o), 64'd299);
        check_val("tail_count", 64'(count_o), 64'd4);

        // Tie: older entry stays ahead
        do_clear();
        check_val("clr_count", 64'(count_o), 64'd0);
        check_val("clr_limit", 64'(limit_o), 64'h3FF);
        push(10'd200, 64'hA);
        push(10'd200, 64'hB);
        tick();
        tick();
        check_slot(0, 10'd200, 64'hA);
        check_slot(1, 10'd200, 64'hB);
        check_val("tie_count", 64'(count_o), 64'd2);

        // Threshold load blocks intake that cycle, then filters candidates
        do_clear();
        load_i = 1'b1;
        load_score_i = 10'd150;
        cif.cand_valid = 1'b1;
        cif.cand_score = 10'd10;
        cif.cand_tag   = 64'hEE;
        #1;
        $display("load threshold=150 with candidate offered");
        check_val("load_ready", 64'(cif.cand_ready), 64'd0);
        tick();
        load_i = 1'b0;
        cif.cand_valid = 1'b0;
        tick();
        tick();
        check_val("load_not_taken", 64'(count_o), 64'd0);
        check_val("load_limit", 64'(limit_o), 64'd150);
        push(10'd180, 64'hC);
        push(10'd120, 64'hD);
        tick();
        tick();
        check_val("thr_count", 64'(count_o), 64'd1);
        check_val("thr_best_score", 64'(best_score_o), 64'd120);
        check_val("thr_best_tag", best_tag_o, 64'hD);
        check_val("thr_limit", 64'(limit_o), 64'd150);

        // Clear drops an in-flight candidate; threshold is kept
        do_clear();
        push(10'd50, 64'h7);
        do_clear();
        check_val("cif_count", 64'(count_o), 64'd0);
        check_val("cif_best_valid", 64'(best_valid_o), 64'd0);
        check_val("cif_improved", 64'(improved_o), 64'd0);
        check_val("cif_limit", 64'(limit_o), 64'd150);
        tick();
        tick();
        check_val("cif_improved2", 64'(improved_o), 64'd0);
        check_val("cif_count2", 64'(count_o), 64'd0);

        // Reset mid-stream, overriding a simultaneous load
        push(10'd130, 64'h8);
        tick();
        check_val("pre_rst_count", 64'(count_o), 64'd1);
        push(10'd110, 64'h9);
        rst_i = 1'b1;
        load_i = 1'b1;
        load_score_i = 10'd5;
        $display("reset mid-stream with load");
        tick();
        load_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        check_val("mrst_count", 64'(count_o), 64'd0);
        check_val("mrst_limit", 64'(limit_o), 64'h3FF);
        check_val("mrst_best_valid", 64'(best_valid_o), 64'd0);
        check_val("mrst_improved", 64'(improved_o), 64'd0);
        check_slot(0, 10'h3FF, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
